// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS core load/store port: word RAM plus CYCLES/SCRATCH
// MMIO registers, with a fixed wait-state latency and a one-cycle ready pulse per access.
module dmem_responder #(
  parameter int MIPS_SIZE = 32,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req,
  input  logic                 we,
  input  logic [MIPS_SIZE-1:0] addr,
  input  logic [MIPS_SIZE-1:0] wdata,
  output logic [MIPS_SIZE-1:0] rdata,
  output logic                 ready,
  output logic                 err,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
  localparam logic [MIPS_SIZE-1:0] RAM_TOP  = MIPS_SIZE'(DEPTH * 4);
  localparam logic [MIPS_SIZE-1:0] CYC_ADDR = MIPS_SIZE'(32'hFFFF_0000);
  localparam logic [MIPS_SIZE-1:0] SCR_ADDR = MIPS_SIZE'(32'hFFFF_0004);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [MIPS_SIZE-1:0] addr_q, addr_d;
  logic [MIPS_SIZE-1:0] wdata_q, wdata_d;
  logic [MIPS_SIZE-1:0] cycles_q, cycles_d;
  logic [MIPS_SIZE-1:0] scratch_q, scratch_d;
  logic [MIPS_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  logic [MIPS_SIZE-1:0] mem [DEPTH];

  logic                 commit;
  logic                 acc_we;
  logic [MIPS_SIZE-1:0] acc_addr, acc_wdata;
  logic [AW-1:0]        acc_idx;
  logic                 ram_we;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cycles_q  <= '0;
      scratch_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cycles_q  <= cycles_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = (LATENCY == 0) ? RESP : WAIT;
        cnt_d   = CNT_INIT;
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the commit edge is also the accept edge, so decode the live inputs then.
  always_comb begin
    commit    = (state_d == RESP) && (state_q != RESP);
    acc_we    = (state_q == IDLE) ? we    : we_q;
    acc_addr  = (state_q == IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
    acc_idx   = acc_addr[AW+1:2];
  end

  // Output / datapath logic
  always_comb begin
    busy      = (state_q != IDLE);
    rdata_d   = '0;
    err_d     = 1'b0;
    ready_d   = commit;
    ram_we    = 1'b0;
    scratch_d = scratch_q;
    cycles_d  = cycles_q + MIPS_SIZE'(1);
    if (commit) begin
      if (acc_addr[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else if (acc_addr < RAM_TOP) begin
        if (acc_we) ram_we  = 1'b1;
        else        rdata_d = mem[acc_idx];
      end else if (acc_addr == CYC_ADDR) begin
        if (!acc_we) rdata_d = cycles_q;
      end else if (acc_addr == SCR_ADDR) begin
        if (acc_we) scratch_d = acc_wdata;
        else        rdata_d   = scratch_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // RAM is deliberately not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && ram_we) mem[acc_idx] <= acc_wdata;
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = ready_q;

endmodule
